plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/obstacle_pkg.sv | 29 ++
 rtl/rr_pick.sv | 26 ++
 rtl/plot_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_plot_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared widths, limits and state encoding for the plot arbiter and its helpers.
package obstacle_pkg;

    localparam int unsigned X_W          = 8;
    localparam int unsigned Y_W          = 7;
    localparam int unsigned C_W          = 3;
    localparam int unsigned N_REQ        = 3;
    localparam int unsigned LOCK_TIMEOUT = 16;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned CNT_W        = $clog2(LOCK_TIMEOUT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Requester index incremented modulo N_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N_REQ.
module rr_pick
    import obstacle_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = ptr_i;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Three-way frame-buffer arbiter with lock ownership, lock timeout and a tagged read return.
module plot_arbiter
    import obstacle_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] we,
    input  logic [N_REQ-1:0] lock,
    input  logic [X_W-1:0]   x0,
    input  logic [X_W-1:0]   x1,
    input  logic [X_W-1:0]   x2,
    input  logic [Y_W-1:0]   y0,
    input  logic [Y_W-1:0]   y1,
    input  logic [Y_W-1:0]   y2,
    input  logic [C_W-1:0]   c0,
    input  logic [C_W-1:0]   c1,
    input  logic [C_W-1:0]   c2,
    output logic [N_REQ-1:0] gnt,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   plot_color,
    output logic             plot,
    input  logic [C_W-1:0]   image_color,
    output logic [N_REQ-1:0] rvalid,
    output logic [C_W-1:0]   rdata
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   color_q, color_d;
    logic             plot_q, plot_d;

    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic [C_W-1:0]   rdata_q, rdata_d;

    logic [X_W-1:0]   x_in [N_REQ];
    logic [Y_W-1:0]   y_in [N_REQ];
    logic [C_W-1:0]   c_in [N_REQ];

    logic             timeout_now;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_gnt;
    logic [N_REQ-1:0] gnt_int;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;

    assign x_in = '{x0, x1, x2};
    assign y_in = '{y0, y1, y2};
    assign c_in = '{c0, c1, c2};

    // The 16th idle owner cycle reopens arbitration immediately, starting after the owner.
    always_comb begin
        timeout_now = (state_q == LOCKED) && !req[owner_q]
                      && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
        pick_ptr    = (state_q == LOCKED) ? next_idx(owner_q) : ptr_q;
    end

    rr_pick u_rr_pick (
        .req_i (req),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        gnt_int = '0;
        if (!reset) begin
            gnt_int = '0;
        end else if (state_q == IDLE || timeout_now) begin
            gnt_int = pick_gnt;
        end else if (req[owner_q]) begin
            gnt_int = to_onehot(owner_q);
        end
    end

    assign gnt     = gnt_int;
    assign gnt_any = |gnt_int;

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_int[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (gnt_any) begin
            cnt_d = '0;
            if (lock[gnt_idx]) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d = IDLE;
                ptr_d   = next_idx(gnt_idx);
            end
        end else if (state_q == LOCKED) begin
            if (!lock[owner_q] || timeout_now) begin
                state_d = IDLE;
                ptr_d   = next_idx(owner_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        plot_d  = 1'b0;
        if (gnt_any) begin
            x_d     = x_in[gnt_idx];
            y_d     = y_in[gnt_idx];
            color_d = c_in[gnt_idx];
            plot_d  = we[gnt_idx];
        end
    end

    // Read tag travels two stages; image_color is captured as the tag leaves stage 1.
    always_comb begin
        s1_v_d   = gnt_any && !we[gnt_idx];
        s1_idx_d = gnt_idx;
        s2_v_d   = s1_v_q;
        s2_idx_d = s1_idx_q;
        rdata_d  = s1_v_q ? image_color : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            plot_q   <= 1'b0;
            s1_v_q   <= 1'b0;
            s1_idx_q <= '0;
            s2_v_q   <= 1'b0;
            s2_idx_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            plot_q   <= plot_d;
            s1_v_q   <= s1_v_d;
            s1_idx_q <= s1_idx_d;
            s2_v_q   <= s2_v_d;
            s2_idx_q <= s2_idx_d;
            rdata_q  <= rdata_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign plot_color = color_q;
    assign plot       = plot_q;
    assign rvalid     = s2_v_q ? to_onehot(s2_idx_q) : '0;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scenario-driven bench for plot_arbiter with queued expectations for commands and read returns.
module tb_plot_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req, we, lock;
    logic [7:0] x0, x1, x2;
    logic [6:0] y0, y1, y2;
    logic [2:0] c0, c1, c2;
    logic [2:0] gnt;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] plot_color;
    logic       plot;
    logic [2:0] image_color;
    logic [2:0] rvalid;
    logic [2:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } cmd_t;

    typedef struct {
        int         due;
        logic [2:0] rv;
        logic [2:0] rd;
    } rd_t;

    cmd_t       pq[$];
    rd_t        rq[$];
    cmd_t       last;
    logic [2:0] exp_rdata;

    localparam logic [2:0] RD_REQ [7] = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000};
    localparam logic [2:0] RD_IMG [7] = '{3'b000, 3'b101, 3'b111, 3'b110, 3'b001, 3'b010, 3'b000};

    localparam logic [2:0] LK_REQ  [4] = '{3'b011, 3'b010, 3'b011, 3'b010};
    localparam logic [2:0] LK_WE   [4] = '{3'b010, 3'b010, 3'b011, 3'b010};
    localparam logic [2:0] LK_LOCK [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
    localparam logic [2:0] LK_GNT  [4] = '{3'b001, 3'b000, 3'b001, 3'b010};

    plot_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .lock        (lock),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .c0          (c0),
        .c1          (c1),
        .c2          (c2),
        .gnt         (gnt),
        .x           (x),
        .y           (y),
        .plot_color  (plot_color),
        .plot        (plot),
        .image_color (image_color),
        .rvalid      (rvalid),
        .rdata       (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cmd_t cmd_of(input int i);
        cmd_t r;
        case (i)
            0:       r = '{x0, y0, c0, we[0]};
            1:       r = '{x1, y1, c1, we[1]};
            default: r = '{x2, y2, c2, we[2]};
        endcase
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req = 3'b111; we = 3'b111; lock = 3'b000;
        x0 = 8'h11; x1 = 8'h22; x2 = 8'h33;
        y0 = 7'h11; y1 = 7'h22; y2 = 7'h33;
        c0 = 3'd1; c1 = 3'd2; c2 = 3'd3;
        image_color = 3'b111;
        #2 reset = 1'b0;
        #2;
        n_tests++;
        if (gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 000", gnt);
        end
        n_tests++;
        if ({x, y, plot_color, plot, rvalid, rdata} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {x, y, plot_color, plot, rvalid, rdata});
        end
        @(negedge clk);
        req = 3'b000;
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({x, plot} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h expected 0", {x, plot});
        end
        last = '{8'd0, 7'd0, 3'd0, 1'b0};
        exp_rdata = 3'b000;
    endtask

    task automatic test_round_robin();
        int   exp_i;
        cmd_t e;
        req = 3'b111; we = 3'b111; lock = 3'b000;
        for (int c = 0; c < 6; c++) begin
            x0 = 8'(16 * c); x1 = 8'(16 * c + 1); x2 = 8'(16 * c + 2);
            y0 = 7'(4 * c + 1); y1 = 7'(4 * c + 2); y2 = 7'(4 * c + 3);
            c0 = 3'(c); c1 = 3'(c + 1); c2 = 3'(c + 2);
            exp_i = c % 3;
            pq.push_back(cmd_of(exp_i));
            @(negedge clk);
            n_tests++;
            if (gnt !== 3'(1 << exp_i)) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, 3'(1 << exp_i));
            end
            @(posedge clk); #1;
            e = pq.pop_front();
            n_tests++;
            if ({x, y, plot_color, plot} !== {e.x, e.y, e.c, e.p}) begin
                n_fail++;
                $display("FAIL rr_cmd[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b",
                         c, x, y, plot_color, plot, e.x, e.y, e.c, e.p);
            end
            last = e;
        end
        req = 3'b000;
    endtask

    task automatic test_idle();
        req = 3'b000; we = 3'b111;
        for (int k = 0; k < 3; k++) begin
            x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom);
            y0 = 7'($urandom); c1 = 3'($urandom);
            @(negedge clk);
            n_tests++;
            if (gnt !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_gnt[%0d]: got %b expected 000", k, gnt);
            end
            @(posedge clk); #1;
            n_tests++;
            if ({x, y, plot_color, plot} !== {last.x, last.y, last.c, 1'b0}) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got %h/%h/%h/%b expected %h/%h/%h/0",
                         k, x, y, plot_color, plot, last.x, last.y, last.c);
            end
        end
    endtask

    task automatic test_read_latency();
        rd_t        e;
        logic [2:0] exp_rv;
        we = 3'b000; lock = 3'b000;
        x0 = 8'd3; x1 = 8'd10; x2 = 8'd77;
        y0 = 7'd4; y1 = 7'd20; y2 = 7'd99;
        for (int c = 0; c < 7; c++) begin
            exp_rv = 3'b000;
            if (rq.size() > 0 && rq[0].due == c) begin
                e = rq.pop_front();
                exp_rv = e.rv;
                exp_rdata = e.rd;
            end
            n_tests++;
            if ({rvalid, rdata} !== {exp_rv, exp_rdata}) begin
                n_fail++;
                $display("FAIL read_ret[%0d]: got rvalid=%b rdata=%b expected rvalid=%b rdata=%b",
                         c, rvalid, rdata, exp_rv, exp_rdata);
            end
            req = RD_REQ[c];
            image_color = RD_IMG[c];
            if (req != 3'b000) rq.push_back('{c + 2, req, RD_IMG[c + 1]});
            @(negedge clk);
            n_tests++;
            if (gnt !== req) begin
                n_fail++;
                $display("FAIL read_gnt[%0d]: got %b expected %b", c, gnt, req);
            end
            @(posedge clk); #1;
            if (c == 0) begin
                n_tests++;
                if ({x, y, plot} !== {8'd10, 7'd20, 1'b0}) begin
                    n_fail++;
                    $display("FAIL read_addr: got %h/%h/%b expected 0a/14/0", x, y, plot);
                end
            end
        end
        req = 3'b000;
    endtask

    task automatic test_lock_rmw();
        rd_t        e;
        logic [2:0] exp_rv;
        logic       exp_plot;
        image_color = 3'b110;
        x0 = 8'd50; y0 = 7'd60; c0 = 3'd5;
        x1 = 8'd51; y1 = 7'd61; c1 = 3'd6;
        for (int c = 0; c < 4; c++) begin
            exp_rv = 3'b000;
            if (rq.size() > 0 && rq[0].due == c) begin
                e = rq.pop_front();
                exp_rv = e.rv;
                exp_rdata = e.rd;
            end
            n_tests++;
            if ({rvalid, rdata} !== {exp_rv, exp_rdata}) begin
                n_fail++;
                $display("FAIL lock_ret[%0d]: got rvalid=%b rdata=%b expected rvalid=%b rdata=%b",
                         c, rvalid, rdata, exp_rv, exp_rdata);
            end
            req = LK_REQ[c]; we = LK_WE[c]; lock = LK_LOCK[c];
            if ((LK_GNT[c] & ~LK_WE[c]) != 3'b000) rq.push_back('{c + 2, LK_GNT[c], 3'b110});
            exp_plot = |(LK_GNT[c] & LK_WE[c]);
            @(negedge clk);
            n_tests++;
            if (gnt !== LK_GNT[c]) begin
                n_fail++;
                $display("FAIL lock_gnt[%0d]: got %b expected %b", c, gnt, LK_GNT[c]);
            end
            @(posedge clk); #1;
            n_tests++;
            if (plot !== exp_plot) begin
                n_fail++;
                $display("FAIL lock_plot[%0d]: got %b expected %b", c, plot, exp_plot);
            end
        end
        req = 3'b000; lock = 3'b000;
    endtask

    task automatic test_lock_timeout();
        logic [2:0] exp_g;
        we = 3'b111;
        lock = 3'b100;
        for (int k = 0; k < 23; k++) begin
            req = (k == 0) ? 3'b100 : (k == 6) ? 3'b111 : 3'b011;
            exp_g = (k == 0 || k == 6) ? 3'b100 : (k == 22) ? 3'b001 : 3'b000;
            @(negedge clk);
            n_tests++;
            if (gnt !== exp_g) begin
                n_fail++;
                $display("FAIL timeout_gnt[%0d]: got %b expected %b", k, gnt, exp_g);
            end
            @(posedge clk); #1;
            n_tests++;
            if (plot !== (exp_g != 3'b000)) begin
                n_fail++;
                $display("FAIL timeout_plot[%0d]: got %b expected %b", k, plot, exp_g != 3'b000);
            end
        end
        req = 3'b000; lock = 3'b000;
    endtask

    task automatic test_reset_midstream();
        req = 3'b111; we = 3'b000; lock = 3'b000;
        x0 = 8'd201; y0 = 7'd101; c0 = 3'd7;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({gnt, x, y, plot_color, plot, rvalid, rdata} !== 28'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected 0",
                     {gnt, x, y, plot_color, plot, rvalid, rdata});
        end
        we = 3'b111;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL mid_first_gnt: got %b expected 001", gnt);
        end
        @(posedge clk); #1;
        req = 3'b000;
        n_tests++;
        if ({x, y, plot_color, plot} !== {8'd201, 7'd101, 3'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_first_cmd: got %h/%h/%h/%b expected c9/65/7/1",
                     x, y, plot_color, plot);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (rvalid !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_stale_rvalid[%0d]: got %b expected 000", k, rvalid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_idle();
        test_read_latency();
        test_lock_rmw();
        test_lock_timeout();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
